alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-requester arbiter and sequencer wrapped around one instance of the team's 32-bit ALU. It accepts operand/opcode requests from two clients, such as the integer pipe and the address/branch unit. Each client uses a valid/ready handshake and requests are granted round-robin. The block drives the shared ALU from registered operands and returns a registered result, zero flag and requester ID on a single response channel.

## Interface
- WIDTH, 32, operand/result width; the ALU instance is 32-bit, so only 32 is supported
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_req0_valid  input  1  requester 0 has a request
- o_req0_ready  output  1  request 0 accepted this cycle
- i_req0_srca, i_req0_srcb  input  WIDTH  requester 0 operands
- i_req0_ctrl  input  3  requester 0 ALU opcode
- i_req1_valid, o_req1_ready, i_req1_srca, i_req1_srcb, i_req1_ctrl  same as above for requester 1
- o_rsp_valid  output  1  response available
- i_rsp_ready  input  1  consumer takes response
- o_rsp_id  output  1  requester that issued the response
- o_rsp_result  output  WIDTH  ALU result
- o_rsp_zero  output  1  result == 0
- o_rsp_err  output  1  illegal opcode (see Configuration)

## Operation
- Opcodes: 000 add, 001 sub (srca-srcb, wraps mod 2^32), 010 and, 011 or, 101 set-less-than.
  - Set-less-than is an unsigned compare: result 1 if srca<srcb, else 0.
  - 100, 110 and 111 are illegal.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Grant is combinational from the valids and the rr pointer `rr_ptr`.
  - If only one valid is high, that requester wins. If both are high, the requester equal to `rr_ptr` wins.
  - o_reqN_ready = (state==IDLE) && grant==N. Ready is never asserted to both requesters.
  - On handshake, latch srca, srcb, ctrl and id into operand registers, then go to EXEC.
- EXEC: the ALU is driven only from the operand registers. At the clock edge the result, zero and err are captured into the response registers, then go to RESP.
- RESP:
  - o_rsp_valid=1. The response outputs are stable until the handshake completes.
  - On i_rsp_ready, go to IDLE and set `rr_ptr` = ~o_rsp_id.
  - Without i_rsp_ready, stay in RESP (backpressure).
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is legal; the request is then simply not taken.
- Only one transaction is in flight. Requests arriving during EXEC or RESP wait.

## Timing
- Reset values: state=IDLE, rr_ptr=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_zero=0, o_rsp_err=0, o_req0_ready=0 and o_req1_ready=0 (ready outputs are 0 unless a valid is present).
- Latency: request handshake at cycle T gives o_rsp_valid=1 at T+2.
- Throughput with i_rsp_ready held high: one op per 3 cycles. The next grant can occur at T+3.
- Simultaneous valids after reset: requester 0 is served first, then they alternate while both stay valid.
- Fairness: a continuously-valid requester waits at most one other transaction.
- rr_ptr is only updated on response handshake.
- Reset asserted mid-transaction: the transaction is discarded and all outputs take their reset values asynchronously. There is no response after reset release.
- An i_rsp_ready asserted outside RESP is ignored.

## Configuration
- Macro: ALU_SHARE_ARB_ILLEGAL_OP_EN.
- Defined:
  - In EXEC, an illegal ctrl (100, 110, 111) captures o_rsp_result=0, o_rsp_zero=0 and o_rsp_err=1.
  - The ALU output is ignored for that transaction.
  - Legal ops give o_rsp_err=0.
- Undefined:
  - o_rsp_err is tied to 0.
  - An illegal op captures the raw ALU output, which is unspecified. The bench must not check result or zero for illegal ops in this build.

## Test plan
- Req0 srca=5, srcb=7, ctrl=001 alone -> ready0 at T; at T+2: rsp_valid=1, id=0, result=32'hFFFFFFFE, zero=0.
- Req1 srca=9, srcb=9, ctrl=001 -> result=0, zero=1, id=1; req1 ctrl=101 with 3 vs 32'hFFFFFFFF -> result=1 (unsigned).
- Both valid continuously from reset, four ops each -> grants alternate 0,1,0,1…. Never both readys high. Each response id matches its payload.
- i_rsp_ready held low 5 cycles in RESP -> response outputs constant, both readys 0, no new grant. Release -> IDLE the next cycle.
- Assert i_rst_n low during EXEC -> all outputs 0 immediately. After release, no response until a new request.
- With ALU_SHARE_ARB_ILLEGAL_OP_EN: ctrl=110 -> result=0, zero=0, err=1. A following legal add of 1+2 -> result=3, err=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin two-client arbiter sequencing one shared 32-bit ALU.
// Optional ALU_SHARE_ARB_ILLEGAL_OP_EN flags illegal opcodes in o_rsp_err.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_srca,
  input  logic [WIDTH-1:0] i_req0_srcb,
  input  logic [2:0]       i_req0_ctrl,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_srca,
  input  logic [WIDTH-1:0] i_req1_srcb,
  input  logic [2:0]       i_req1_ctrl,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_zero,
  output logic             o_rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] srcb_q, srcb_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic id_q, id_d;
  logic rid_q, rid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic zero_q, zero_d;
  logic gnt_vld, gnt_id, idle;
  logic [WIDTH-1:0] alu_y;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  logic err_q, err_d;
  logic illegal;
`endif

  assign idle    = (state_q == IDLE);
  assign gnt_vld = i_req0_valid | i_req1_valid;

  always_comb begin
    gnt_id = 1'b0;
    unique case ({i_req1_valid, i_req0_valid})
      2'b11:   gnt_id = rr_ptr_q;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

  // Readys are forced low while reset is held so all outputs clear at once.
  assign o_req0_ready = i_rst_n & idle & gnt_vld & ~gnt_id;
  assign o_req1_ready = i_rst_n & idle & gnt_vld & gnt_id;

  always_comb begin
    alu_y = '0;
    case (ctrl_q)
      3'b000:  alu_y = srca_q + srcb_q;
      3'b001:  alu_y = srca_q - srcb_q;
      3'b010:  alu_y = srca_q & srcb_q;
      3'b011:  alu_y = srca_q | srcb_q;
      3'b101:  alu_y = {{(WIDTH-1){1'b0}}, (srca_q < srcb_q)};
      default: alu_y = '0;
    endcase
  end

`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  assign illegal = (ctrl_q == 3'b100) |
                   (ctrl_q == 3'b110) |
                   (ctrl_q == 3'b111);
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    ctrl_d   = ctrl_q;
    id_d     = id_q;
    rid_d    = rid_q;
    res_d    = res_q;
    zero_d   = zero_q;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          srca_d  = gnt_id ? i_req1_srca : i_req0_srca;
          srcb_d  = gnt_id ? i_req1_srcb : i_req0_srcb;
          ctrl_d  = gnt_id ? i_req1_ctrl : i_req0_ctrl;
          id_d    = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rid_d   = id_q;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
        res_d   = illegal ? '0 : alu_y;
        zero_d  = ~illegal & (alu_y == '0);
        err_d   = illegal;
`else
        res_d   = alu_y;
        zero_d  = (alu_y == '0);
`endif
        state_d = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rr_ptr_d = ~rid_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      srca_q   <= '0;
      srcb_q   <= '0;
      ctrl_q   <= '0;
      id_q     <= 1'b0;
      rid_q    <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      ctrl_q   <= ctrl_d;
      id_q     <= id_d;
      rid_q    <= rid_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
      err_q    <= err_d;
`endif
    end
  end

  assign o_rsp_valid  = (state_q == RESP);
  assign o_rsp_id     = rid_q;
  assign o_rsp_result = res_q;
  assign o_rsp_zero   = zero_q;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  assign o_rsp_err    = err_q;
`else
  assign o_rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset, ops, alternation,
// backpressure, mid-flight reset and illegal opcodes.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, r0, r1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  c0, c1;
  logic        rsp_valid, rsp_rdy, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (v0),
    .o_req0_ready (r0),
    .i_req0_srca  (a0),
    .i_req0_srcb  (b0),
    .i_req0_ctrl  (c0),
    .i_req1_valid (v1),
    .o_req1_ready (r1),
    .i_req1_srca  (a1),
    .i_req1_srcb  (b1),
    .i_req1_ctrl  (c1),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_rdy),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_res),
    .o_rsp_zero   (rsp_zero),
    .o_rsp_err    (rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, waits for the response, pulses i_rsp_ready.
  // lat = cycles from handshake cycle to rsp_valid (expected 2).
  task automatic run_op(input logic id,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [2:0] ctrl,
                        output logic [31:0] res,
                        output logic zero,
                        output logic err,
                        output logic rid,
                        output int lat);
    int n;
    if (id) begin
      v1 = 1'b1; a1 = a; b1 = b; c1 = ctrl;
    end else begin
      v0 = 1'b1; a0 = a; b0 = b; c0 = ctrl;
    end
    #1;
    n = 0;
    while (!(id ? r1 : r0) && n < 10) begin
      tick();
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      tick();
      lat++;
    end
    res  = rsp_res;
    zero = rsp_zero;
    err  = rsp_err;
    rid  = rsp_id;
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 0; v1 = 0; rsp_rdy = 0;
    a0 = 0; b0 = 0; c0 = 0;
    a1 = 0; b1 = 0; c1 = 0;
    #2;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=0", rsp_valid);
    end
    total++;
    if ({rsp_id, rsp_zero, rsp_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000",
               {rsp_id, rsp_zero, rsp_err});
    end
    total++;
    if (rsp_res !== 32'h0) begin
      bad++;
      $display("FAIL reset_result got=%h exp=0", rsp_res);
    end
    total++;
    if ({r0, r1} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=00", {r0, r1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({rsp_valid, r0, r1} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset got=%b exp=000",
               {rsp_valid, r0, r1});
    end
  endtask

  task automatic test_sub_req0();
    logic [31:0] res;
    logic zero, err, rid;
    int lat;
    run_op(1'b0, 32'd5, 32'd7, 3'b001, res, zero, err, rid, lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL sub_latency got=%0d exp=2", lat);
    end
    total++;
    if (res !== 32'hFFFFFFFE) begin
      bad++;
      $display("FAIL sub_result got=%h exp=fffffffe", res);
    end
    total++;
    if ({rid, zero, err} !== 3'b000) begin
      bad++;
      $display("FAIL sub_flags got=%b exp=000", {rid, zero, err});
    end
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL sub_drain got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_ops();
    logic [31:0] res;
    logic zero, err, rid;
    int lat;
    run_op(1'b1, 32'd9, 32'd9, 3'b001, res, zero, err, rid, lat);
    total++;
    if ({res, zero, rid} !== {32'h0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL sub_zero got=%h/%b/%b exp=0/1/1",
               res, zero, rid);
    end
    run_op(1'b1, 32'd3, 32'hFFFFFFFF, 3'b101, res, zero, err, rid, lat);
    total++;
    if ({res, zero, rid} !== {32'h1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL sltu got=%h/%b/%b exp=1/0/1", res, zero, rid);
    end
    run_op(1'b1, 32'hFFFFFFFF, 32'd3, 3'b101, res, zero, err, rid, lat);
    total++;
    if ({res, zero} !== {32'h0, 1'b1}) begin
      bad++;
      $display("FAIL sltu_ge got=%h/%b exp=0/1", res, zero);
    end
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, 3'b000, res, zero, err, rid, lat);
    total++;
    if ({res, zero, rid} !== {32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add_wrap got=%h/%b/%b exp=0/1/0",
               res, zero, rid);
    end
    run_op(1'b0, 32'h0000F0F0, 32'h0000FF00, 3'b010,
           res, zero, err, rid, lat);
    total++;
    if (res !== 32'h0000F000) begin
      bad++;
      $display("FAIL and got=%h exp=0000f000", res);
    end
    run_op(1'b1, 32'h0000000F, 32'h000000F0, 3'b011,
           res, zero, err, rid, lat);
    total++;
    if ({res, err} !== {32'h000000FF, 1'b0}) begin
      bad++;
      $display("FAIL or got=%h/%b exp=000000ff/0", res, err);
    end
  endtask

  task automatic test_alternate();
    logic [32:0] q[$];
    logic [32:0] e;
    logic [31:0] expv;
    logic g0, g1;
    int k0, k1, ng, last, cyc;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    k0 = 0; k1 = 0; ng = 0; last = -1;
    rsp_rdy = 1'b1;
    for (cyc = 0; cyc < 100 && (ng < 8 || q.size() > 0); cyc++) begin
      v0 = (k0 < 4); a0 = 32'(10 * k0); b0 = 32'd1; c0 = 3'b000;
      v1 = (k1 < 4); a1 = 32'd100; b1 = 32'(k1); c1 = 3'b001;
      #1;
      g0 = r0;
      g1 = r1;
      if (g0 && g1) begin
        total++;
        bad++;
        $display("FAIL alt_both_ready cyc=%0d got=11 exp=one", cyc);
      end
      if (rsp_valid) begin
        e = (q.size() > 0) ? q.pop_front() : 33'h1_FFFF_FFFF;
        total++;
        if ({rsp_id, rsp_res} !== e) begin
          bad++;
          $display("FAIL alt_rsp got=%b/%h exp=%b/%h",
                   rsp_id, rsp_res, e[32], e[31:0]);
        end
      end
      if (g0 || g1) begin
        total++;
        if (g1 !== ng[0]) begin
          bad++;
          $display("FAIL alt_grant n=%0d got=%b exp=%b", ng, g1, ng[0]);
        end
        if (last >= 0) begin
          total++;
          if (cyc - last != 3) begin
            bad++;
            $display("FAIL alt_spacing got=%0d exp=3", cyc - last);
          end
        end
        last = cyc;
        expv = g1 ? 32'(100 - k1) : 32'(10 * k0 + 1);
        q.push_back({g1, expv});
        ng++;
      end
      @(posedge clk);
      #1;
      if (g0) k0++;
      if (g1) k1++;
    end
    total++;
    if (ng != 8 || q.size() != 0) begin
      bad++;
      $display("FAIL alt_done got=%0d/%0d exp=8/0", ng, q.size());
    end
    v0 = 1'b0;
    v1 = 1'b0;
    rsp_rdy = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    v0 = 1'b1; a0 = 32'd2; b0 = 32'd3; c0 = 3'b000;
    #1;
    total++;
    if ({r0, r1} !== 2'b10) begin
      bad++;
      $display("FAIL bp_grant got=%b exp=10", {r0, r1});
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b1; a1 = 32'd7; b1 = 32'd7; c1 = 3'b000;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_id, rsp_zero, r0, r1, rsp_res} !==
          {5'b10000, 32'd5}) begin
        bad++;
        $display("FAIL bp_hold i=%0d got=%b%b%b%b%b/%h exp=10000/5",
                 i, rsp_valid, rsp_id, rsp_zero, r0, r1, rsp_res);
      end
      tick();
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    total++;
    if ({rsp_valid, r0, r1} !== 3'b001) begin
      bad++;
      $display("FAIL bp_release got=%b exp=001",
               {rsp_valid, r0, r1});
    end
    v1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    v1 = 1'b1; a1 = 32'd5; b1 = 32'd6; c1 = 3'b000;
    #1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_err, r0, r1} !== 6'b0) begin
      bad++;
      $display("FAIL rstmid_flags got=%b exp=000000",
               {rsp_valid, rsp_id, rsp_zero, rsp_err, r0, r1});
    end
    total++;
    if (rsp_res !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_result got=%h exp=0", rsp_res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_no_rsp i=%0d got=%b exp=0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] res;
    logic zero, err, rid;
    int lat;
    run_op(1'b0, 32'd1, 32'd2, 3'b110, res, zero, err, rid, lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL ill_latency got=%0d exp=2", lat);
    end
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
    total++;
    if ({res, zero, err} !== {32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ill_op got=%h/%b/%b exp=0/0/1", res, zero, err);
    end
`else
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL ill_err_tied got=%b exp=0", err);
    end
`endif
    run_op(1'b1, 32'd1, 32'd2, 3'b000, res, zero, err, rid, lat);
    total++;
    if ({res, zero, err, rid} !== {32'd3, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ill_then_add got=%h/%b/%b/%b exp=3/0/0/1",
               res, zero, err, rid);
    end
  endtask

  initial begin
    test_reset();
    test_sub_req0();
    test_ops();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
